// File: rtl/ones_cnt_sched_pkg.sv
// Shared widths and FSM encoding for the ones-count scheduler.
package ones_cnt_sched_pkg;

  localparam int data_size = 8;
  localparam int r2_size   = $clog2(data_size + 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_RUN  = 4'b0100,
    ST_DONE = 4'b1000
  } sched_state_t;

endpackage

// File: rtl/ones_cnt_sched_rr_arbiter.sv
// Request arbiter: round-robin when ONES_CNT_SCHED_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no pointer register.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  input  logic [NUM_REQ-1:0] i_owner,
  output logic [NUM_REQ-1:0] o_winner
);

`ifdef ONES_CNT_SCHED_RR_EN
  localparam int PW = $clog2(NUM_REQ);
  localparam int IW = PW + 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // Search starts at the pointer and wraps modulo NUM_REQ.
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + IW'(k);
      if (w_idx >= IW'(NUM_REQ)) w_idx = w_idx - IW'(NUM_REQ);
      if (!w_found && i_req[w_idx[PW-1:0]]) begin
        w_found                  = 1'b1;
        o_winner[w_idx[PW-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_owner[k]) w_ptr_next = (k == NUM_REQ - 1) ? '0 : PW'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         r_ptr <= '0;
    else if (i_advance) r_ptr <= w_ptr_next;
  end
`else
  logic w_found;
  logic w_unused;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[k]) begin
        w_found     = 1'b1;
        o_winner[k] = 1'b1;
      end
    end
  end

  assign w_unused = ^{clk, rst_b, i_advance, i_owner};
`endif

endmodule

// File: rtl/ones_cnt_sched.sv
// Shares one shift/accumulate popcount engine among NUM_REQ requesters.
// Arbitration policy selected by ONES_CNT_SCHED_RR_EN (round-robin when defined).
module ones_cnt_sched
  import ones_cnt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*data_size-1:0] req_data,
  output logic                         dp_load_regs,
  output logic                         dp_add_shift,
  output logic [data_size-1:0]         dp_data,
  input  logic                         dp_zero,
  input  logic [r2_size-1:0]           dp_cnt,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [r2_size-1:0]           result,
  output logic                         busy
);

  sched_state_t       r_state, w_state_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [NUM_REQ-1:0] r_done, w_done_next;
  logic [r2_size-1:0] r_result, w_result_next;
  logic [NUM_REQ-1:0] w_winner;
  logic               w_advance;

  assign w_advance = (r_state == ST_DONE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_b     (rst_b),
    .i_req     (req),
    .i_advance (w_advance),
    .i_owner   (r_grant),
    .o_winner  (w_winner)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_done   <= w_done_next;
      r_result <= w_result_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_done_next   = '0;
    w_result_next = r_result;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_grant_next = w_winner;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: w_state_next = ST_RUN;
      ST_RUN: begin
        if (dp_zero) begin
          w_result_next = dp_cnt;
          w_done_next   = r_grant;
          w_state_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand mux follows the registered grant, so it reads 0 while idle.
  always_comb begin
    dp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) dp_data = req_data[i*data_size +: data_size];
    end
  end

  assign dp_load_regs = (r_state == ST_LOAD);
  assign dp_add_shift = (r_state == ST_RUN) && !dp_zero;
  assign busy         = (r_state != ST_IDLE);
  assign grant        = r_grant;
  assign done         = r_done;
  assign result       = r_result;

endmodule

// File: doc/ones_cnt_sched.md
# ones_cnt_sched

Scheduler that shares one ones-counting datapath between NUM_REQ requesters. The datapath is the shift/accumulate engine with `load_regs`, `add_shift`, `data_in`, `zero` and `cnt`. The block arbitrates among requests, sequences the datapath through load and shift, and returns the popcount to the winning requester with a one-cycle done pulse. It replaces a single-user controller wherever several clients need popcounts from one engine.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- req  in  NUM_REQ  level request per requester; data must be held stable while req is high
- req_data  in  NUM_REQ*data_size  flattened operands; slot i = bits [i*data_size +: data_size]
- dp_load_regs  out  1  datapath load strobe
- dp_add_shift  out  1  datapath shift/accumulate enable
- dp_data  out  data_size  operand of the granted requester, driven to datapath `data_in`
- dp_zero  in  1  datapath operand register is zero
- dp_cnt  in  r2_size  datapath running count
- grant  out  NUM_REQ  one-hot index of the owner; all zero in IDLE
- done  out  NUM_REQ  one-hot, one-cycle completion pulse
- result  out  r2_size  last completed count; held until the next completion
- busy  out  1  high whenever state is not IDLE

## Operation
- State machine, one-hot encoded: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - If any req is high, the arbiter picks winner g, grant <= onehot(g), go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - dp_load_regs = 1 for exactly one cycle.
  - Go to RUN.
- **RUN**
  - dp_add_shift = !dp_zero.
  - If dp_zero = 1: result <= dp_cnt, done <= grant, go to DONE.
- **DONE**
  - done is high for this cycle only.
  - grant <= 0. Arbiter pointer <= g+1, mod NUM_REQ.
  - Go to IDLE.
- dp_data = req_data slot selected by grant, combinational. It is 0 when grant = 0.
- dp_load_regs and dp_add_shift are never asserted together, and both are 0 in IDLE and DONE.
- Dropping req after grant does not abort the operation. It completes and done still pulses.
- A requester must drop req in the cycle after done unless it wants a new operation. A req still high in IDLE is a new request.
- Arbitration sees only req; ungranted requests wait with no limit on wait time.
- Width rule: r2_size ≥ clog2(data_size+1), so an all-ones operand does not overflow.
- Reset values: grant = 0, done = 0, result = 0, busy = 0, dp_load_regs = 0, dp_add_shift = 0, state = IDLE, arbiter pointer = 0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced for the aborted request.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- Let m be the index of the highest set bit of the operand plus 1; m = 0 for a zero operand.
- Cycle 1 is LOAD. RUN occupies cycles 2..m+2: m shift cycles, then one cycle with dp_zero = 1.
- done and the updated result appear in cycle m+3.
- Minimum latency is 3 cycles (zero operand). Maximum is data_size+3.
- The earliest next grant is sampled in cycle m+4, so there is one IDLE cycle between back-to-back operations.

## Configuration
- Macro: ONES_CNT_SCHED_RR_EN.
- Defined: round-robin arbitration. Search starts at the pointer; the pointer moves to g+1 on each DONE.
- Undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Shared package holds data_size and r2_size (already present) plus the new typedef `sched_state_t` (one-hot state encoding).
- One sub-module: `rr_arbiter`, parameterised by NUM_REQ.
  - Inputs: req and the advance strobe.
  - Output: one-hot winner.
  - Contains the pointer when ONES_CNT_SCHED_RR_EN is defined.

## Test plan
- Single req[0], data 8'b0000_1011 → grant = 0001 in cycles 1..7; done[0] pulses in cycle 7; result = 3; 4 add_shift cycles.
- req[2], data 0 → no add_shift; done[2] in cycle 3; result = 0.
- req[1], data all ones (0xFF) → done in cycle 11 with data_size = 8; result = 8; no overflow.
- req = 0101 held continuously, RR defined → grants alternate 0001, 0100, 0001, …; one IDLE cycle between operations. RR undefined → req[0] wins every round.
- Drop req[3] in the cycle after its grant → operation still finishes; done[3] pulses; result correct.
- rst_b low during RUN → all outputs 0 asynchronously; no done pulse. After release, a held req restarts from IDLE with a correct result.
